fless: RTL and testbench

FLESS -- requirements
Module: fless

---
 rtl/fpu_pkg.sv | 22 ++
 rtl/fless_if.sv | 17 +
 rtl/fp_mag_lt.sv | 20 ++
 rtl/fless.sv | 72 +++++++
 tb/tb_fless.sv | 153 +++++++++++++++
 5 files changed

// File: rtl/fpu_pkg.sv
// ---------------------------------------------------------------------------
// fpu_pkg
// Shared single-precision field constants and a field view of a binary32 word.
// Imported by the comparator top level and by anything else that needs to
// pick IEEE-754 binary32 words apart by field.
// ---------------------------------------------------------------------------
package fpu_pkg;

    localparam int unsigned EXP_MSB = 30;
    localparam int unsigned EXP_LSB = 23;
    localparam int unsigned MAN_W   = 23;
    localparam logic [7:0]  EXP_MAX = 8'hFF;

    // Field view of a binary32 word; bit layout matches the raw vector
    // so a plain cast splits sign, exponent and mantissa.
    typedef struct packed {
        logic             sign;
        logic [7:0]       exp;
        logic [MAN_W-1:0] man;
    } float32_t;

endpackage

// File: rtl/fless_if.sv
// ---------------------------------------------------------------------------
// fless_if
// Bundles the comparator operands and result.
//   x1, x2 : binary32 operands A and B
//   y      : 1 when A < B
// master drives the operands and observes y; slave is the comparator side.
// ---------------------------------------------------------------------------
interface fless_if;

    logic [31:0] x1;
    logic [31:0] x2;
    logic        y;

    modport master (output x1, output x2, input y);
    modport slave  (input x1, input x2, output y);

endinterface

// File: rtl/fp_mag_lt.sv
// ---------------------------------------------------------------------------
// fp_mag_lt
// Unsigned 31-bit magnitude comparator for sign-stripped binary32 words.
// Because exponent sits above mantissa, unsigned order of {exp, man} is the
// same as numeric order of the magnitudes (infinities included).
//   a, b : 31-bit magnitudes
//   lt   : a < b
//   eq   : a == b
// ---------------------------------------------------------------------------
module fp_mag_lt (
    input  logic [30:0] a,
    input  logic [30:0] b,
    output logic        lt,
    output logic        eq
);

    assign lt = (a < b);
    assign eq = (a == b);

endmodule

// File: rtl/fless.sv
// ---------------------------------------------------------------------------
// fless
// Combinational IEEE-754 binary32 ordered less-than: y = (x1 < x2).
// Denormals flush to a zero of their own sign, +0 equals -0, any NaN
// operand forces y to 0.
//   x1   : operand A
//   x2   : operand B
//   y    : 1 when A < B
//   clk  : system clock, unused (no storage in this block)
//   rstn : synchronous active-high reset, unused; any later pipeline
//          register here should clear to 0 while it is high
// ---------------------------------------------------------------------------
module fless
    import fpu_pkg::*;
(
    input  logic [31:0] x1,
    input  logic [31:0] x2,
    output logic        y,
    input  logic        clk,
    input  logic        rstn
);

    float32_t    a;
    float32_t    b;
    logic        a_zero;
    logic        b_zero;
    logic        a_nan;
    logic        b_nan;
    logic [30:0] a_mag;
    logic [30:0] b_mag;
    logic        mag_lt;
    logic        mag_eq;

    // Clock and reset are accepted for drop-in compatibility only.
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ rstn;

    assign a = float32_t'(x1);
    assign b = float32_t'(x2);

    assign a_zero = (a.exp == 8'h00);
    assign b_zero = (b.exp == 8'h00);
    assign a_nan  = (a.exp == EXP_MAX) && (a.man != '0);
    assign b_nan  = (b.exp == EXP_MAX) && (b.man != '0);

    // Flushing denormal magnitudes to zero makes same-sign zero/denormal
    // pairs compare equal without a separate special case.
    assign a_mag = a_zero ? 31'd0 : x1[EXP_MSB:0];
    assign b_mag = b_zero ? 31'd0 : x2[EXP_MSB:0];

    fp_mag_lt u_mag_lt (
        .a  (a_mag),
        .b  (b_mag),
        .lt (mag_lt),
        .eq (mag_eq)
    );

    // Sign combination: for two negatives the larger magnitude is smaller,
    // and a negative/positive pair is ordered unless both are zeros.
    always_comb begin
        y = 1'b0;
        if (!a_nan && !b_nan) begin
            unique case ({a.sign, b.sign})
                2'b00:   y = mag_lt;
                2'b11:   y = !mag_lt && !mag_eq;
                2'b10:   y = !(a_zero && b_zero);
                default: y = 1'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_fless.sv
// ---------------------------------------------------------------------------
// tb_fless
// Self-checking bench for fless: directed corner vectors followed by
// randomized operands compared against a reference built on real-number
// comparison.
// ---------------------------------------------------------------------------
module tb_fless;

    logic clk;
    logic rstn;
    int   vectors;
    int   miscompares;

    fless_if bus ();

    fless dut (
        .x1   (bus.x1),
        .x2   (bus.x2),
        .y    (bus.y),
        .clk  (clk),
        .rstn (rstn)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Widen a binary32 word to a real; exponent-0 words become signed zero.
    function automatic real to_real(input logic [31:0] f);
        logic [10:0] e;
        if (f[30:23] == 8'h00)
            return f[31] ? -0.0 : 0.0;
        if (f[30:23] == 8'hFF)
            e = 11'h7FF;
        else
            e = 11'(f[30:23]) + 11'd896;
        return $bitstoreal({f[31], e, f[22:0], 29'b0});
    endfunction

    function automatic logic is_nan(input logic [31:0] f);
        return (f[30:23] == 8'hFF) && (f[22:0] != 23'd0);
    endfunction

    function automatic logic ref_lt(input logic [31:0] a, input logic [31:0] b);
        if (is_nan(a) || is_nan(b))
            return 1'b0;
        return (to_real(a) < to_real(b)) ? 1'b1 : 1'b0;
    endfunction

    // Random operand with exponent biased toward 0, 255 and nearby values.
    function automatic logic [31:0] rand_float();
        logic [31:0] f;
        int unsigned sel;
        f   = $urandom;
        sel = $urandom_range(0, 9);
        case (sel)
            0: f[30:23] = 8'h00;
            1: f[30:23] = 8'hFF;
            2: f[30:0]  = 31'd0;
            3: f[30:0]  = 31'h7F800000;
            default: ;
        endcase
        return f;
    endfunction

    function automatic logic [31:0] sanitize(input logic [31:0] f);
        logic [31:0] s;
        s = f;
        if (s[30:23] == 8'hFF && s[22:0] != 23'd0)
            s = 32'h7F800000;
        else if (s[30:23] == 8'h00 && s[22:0] != 23'd0)
            s = 32'h00000000;
        return s;
    endfunction

    task automatic check_output(input string tag, input logic observed, input logic expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: x1=%h x2=%h y=%b expected %b",
                     tag, bus.x1, bus.x2, observed, expected);
        end
    endtask

    // Operands change on the falling edge and are sampled 1 unit later,
    // well clear of the rising edge.
    task automatic apply_stimulus(input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        bus.x1 = a;
        bus.x2 = b;
        #1;
    endtask

    task automatic directed(input string tag, input logic [31:0] a,
                            input logic [31:0] b, input logic expected);
        apply_stimulus(a, b);
        check_output(tag, bus.y, expected);
    endtask

    initial begin
        logic [31:0] a;
        logic [31:0] b;
        vectors     = 0;
        miscompares = 0;
        rstn        = 1'b1;
        bus.x1      = 32'h0;
        bus.x2      = 32'h0;

        // Output must follow inputs even while reset is held.
        directed("rst_1lt2",   32'h3F800000, 32'h40000000, 1'b1);
        directed("rst_2lt1",   32'h40000000, 32'h3F800000, 1'b0);
        repeat (2) @(posedge clk);
        rstn = 1'b0;

        directed("one_lt_two",  32'h3F800000, 32'h40000000, 1'b1);
        directed("two_lt_one",  32'h40000000, 32'h3F800000, 1'b0);
        directed("nzero_pzero", 32'h80000000, 32'h00000000, 1'b0);
        directed("pzero_nzero", 32'h00000000, 32'h80000000, 1'b0);
        directed("m2_lt_m1",    32'hC0000000, 32'hBF800000, 1'b1);
        directed("m1_lt_m2",    32'hBF800000, 32'hC0000000, 1'b0);
        directed("ninf_pinf",   32'hFF800000, 32'h7F800000, 1'b1);
        directed("pinf_pinf",   32'h7F800000, 32'h7F800000, 1'b0);
        directed("ninf_ninf",   32'hFF800000, 32'hFF800000, 1'b0);
        directed("same_bits",   32'h12345678, 32'h12345678, 1'b0);
        directed("nan_vs_one",  32'h7FC00000, 32'h3F800000, 1'b0);
        directed("one_vs_nan",  32'h3F800000, 32'h7FC00000, 1'b0);
        directed("ndenorm_pz",  32'h80000001, 32'h00000000, 1'b0);
        directed("ndenorm_p1",  32'h80000001, 32'h3F800000, 1'b1);
        directed("ndenorm_pd",  32'h80400000, 32'h00000005, 1'b0);
        directed("max_lt_inf",  32'h7F7FFFFF, 32'h7F800000, 1'b1);
        directed("ninf_lt_nmx", 32'hFF800000, 32'hFF7FFFFF, 1'b1);

        // Sanitized regression, roughly half with equal operands.
        for (int i = 0; i < 3000; i++) begin
            a = sanitize(rand_float());
            b = ($urandom_range(0, 1) == 0) ? a : sanitize(rand_float());
            apply_stimulus(a, b);
            check_output("rand_clean", bus.y, ref_lt(a, b));
        end

        // Raw operands, including NaNs and denormals, with reset toggling.
        for (int i = 0; i < 2000; i++) begin
            a    = rand_float();
            b    = ($urandom_range(0, 3) == 0) ? a : rand_float();
            rstn = ($urandom_range(0, 7) == 0);
            apply_stimulus(a, b);
            check_output("rand_raw", bus.y, ref_lt(a, b));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
